fetch_ifu: RTL and testbench
============================

# fetch_ifu

Instruction fetch initiator driving the icache fetch port: holds the fetch PC, issues one word request per cycle, tracks in-flight responses, and buffers returned instructions in a small in-order queue for decode. It sits between the backend redirect source (branch/ROB flush) and decode. It is the requesting end of the icache fetch protocol: requests are pipelined, responses return in order with fixed latency, and flush kills everything in flight.

## Interface
- RESET_ADDR, 30'h2000_0000: word address [31:2] fetched first after reset (byte 0x8000_0000).
- FQ_DEPTH, 4: instruction queue entries; power of two, 2..16.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  restart fetch at redirect_addr; flushes icache and queue
- redirect_addr  in  30  new word PC [31:2]
- fetch_ic_req  out  1  request valid this cycle
- fetch_ic_addr  out  30  request word address [31:2]
- fetch_ic_flush  out  1  kill all icache in-flight requests
- icache_ready  in  1  icache accepts a request this cycle
- icache_valid  in  1  response valid (in request order)
- icache_error  in  1  response carries an access fault
- icache_data  in  32  response instruction word
- fetch_de_valid  out  1  instruction available to decode
- fetch_de_addr  out  30  PC [31:2] of offered instruction
- fetch_de_insn  out  32  offered instruction
- fetch_de_error  out  1  offered instruction faulted
- decode_ready  in  1  decode consumes offered instruction when fetch_de_valid

## Operation
- State: RUN (issuing) or HALT (error seen, no issue). Reset -> RUN.
- Registers: pc (next request), resp_pc (address of next response), inflight counter (log2(FQ_DEPTH)+1 bits), FIFO of {addr, insn, error}, count.
- Issue: fetch_ic_req = RUN & icache_ready & !redirect_valid & !rst & (count + inflight < FQ_DEPTH); fetch_ic_addr = pc. On issue pc <= pc+1 (30-bit wrap 3FFF_FFFF -> 0), inflight+1.
- Credit rule guarantees every response has a queue slot; responses are never backpressured. Dequeue in same cycle does not free credit for issue.
- Response (icache_valid, no redirect): inflight-1, resp_pc+1. If RUN: enqueue {resp_pc, icache_data, icache_error}; if icache_error, state -> HALT. If HALT: response dropped (younger than the fault).
- Dequeue: fetch_de_valid & decode_ready pops head. Simultaneous enqueue and dequeue keep count constant; full queue with dequeue + enqueue legal.
- Redirect (priority over all except rst): fetch_ic_flush=1; queue cleared, inflight <= 0, pc and resp_pc <= redirect_addr, state <= RUN; icache_valid that cycle ignored; no request that cycle; decode handshake that cycle ignored.
- fetch_ic_flush = rst | redirect_valid (combinational).
- rst mid-operation: all state reinitialised, pc = resp_pc = RESET_ADDR, in-flight responses ignored via flush.

## Timing
- Reset values (during rst): fetch_ic_req 0, fetch_ic_flush 1, fetch_de_valid 0, fetch_de_error 0; addr/insn don't care.
- First request cycle after rst deasserts, addr RESET_ADDR.
- Request at cycle N -> icache_valid at N+2 -> fetch_de_valid at N+3 (queue path).
- FQ_DEPTH>=4 with decode_ready held high sustains 1 instruction/cycle; FQ_DEPTH=2 does not.
- Redirect at cycle R: new request at R+1 with redirect_addr, first instruction to decode at R+4 (R+3 with bypass).
- fetch_de_* held stable while fetch_de_valid & !decode_ready.

## Configuration
- FETCH_BYPASS_EN defined: when queue empty, decode_ready=1, state RUN, no redirect, an arriving response is presented combinationally on fetch_de_* the same cycle and consumed without enqueue (latency N+2). Faulting response may bypass; state still -> HALT.
- Undefined: all responses pass through the queue; latency N+3; fetch_de_* purely registered.

## Test plan
- Reset, decode_ready=1, icache always ready: requests 2000_0000, 2000_0001, ... every cycle; decode sees same PCs in order with data, first at cycle 3 (2 with bypass), one per cycle thereafter.
- decode_ready=0 for 10 cycles: exactly FQ_DEPTH responses queued, fetch_ic_req drops after count+inflight=FQ_DEPTH, no response lost; release -> in-order drain, addresses contiguous.
- Redirect to 0000_0100 with 2 requests in flight: fetch_ic_flush=1 that cycle, queue empties, next request 0000_0100, stale icache_valid ignored, decode next sees 0000_0100.
- icache_error on response for 2000_0002: that entry delivered with fetch_de_error=1, later in-flight response dropped, no further requests; redirect resumes RUN.
- pc 3FFF_FFFF: next request addr 0000_0000; icache_ready=0 for 3 cycles stalls issue with pc unchanged.
- rst asserted mid-stream with full queue: fetch_de_valid=0 next cycle, restart at 2000_0000.

Source files
------------

// File: rtl/fetch_ifu.sv
// fetch_ifu: icache fetch-port initiator with credit-limited issue and an in-order decode queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_ifu #(
    parameter logic [29:0] RESET_ADDR = 30'h2000_0000,
    parameter int unsigned FQ_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_addr,
    output logic        fetch_ic_req,
    output logic [29:0] fetch_ic_addr,
    output logic        fetch_ic_flush,
    input  logic        icache_ready,
    input  logic        icache_valid,
    input  logic        icache_error,
    input  logic [31:0] icache_data,
    output logic        fetch_de_valid,
    output logic [29:0] fetch_de_addr,
    output logic [31:0] fetch_de_insn,
    output logic        fetch_de_error,
    input  logic        decode_ready
);
    localparam int unsigned   AW        = $clog2(FQ_DEPTH);
    localparam logic [AW+1:0] DEPTH_LIM = (AW+2)'(FQ_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic {RUN, HALT} state_t;
    state_t state_q, state_d;

    logic [29:0]   pc_q, resp_pc_q;
    logic [AW:0]   inflight_q, count_q;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [29:0]   fq_addr [FQ_DEPTH];
    logic [31:0]   fq_insn [FQ_DEPTH];
    logic          fq_err  [FQ_DEPTH];

    logic          running, q_empty, issue, resp, bypass, enq, deq;
    logic [AW+1:0] credit_used;

    assign running     = (state_q == RUN);
    assign q_empty     = (count_q == '0);
    // Every issued request owns a queue slot until it is dequeued, so responses never stall.
    assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue       = running && icache_ready && !redirect_valid && !rst
                         && (credit_used < DEPTH_LIM);
    assign resp        = icache_valid && !redirect_valid && !rst;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp && running && q_empty && decode_ready;
`else
    assign bypass = 1'b0;
`endif

    assign enq = resp && running && !bypass;
    assign deq = !rst && !redirect_valid && !q_empty && decode_ready;

    always_comb begin
        state_d = state_q;
        if (resp && running && icache_error)
            state_d = HALT;
    end

    assign fetch_ic_req   = issue;
    assign fetch_ic_addr  = pc_q;
    assign fetch_ic_flush = rst | redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign fetch_de_valid = !rst && (!q_empty || bypass);
    assign fetch_de_addr  = bypass ? resp_pc_q   : fq_addr[rd_ptr_q];
    assign fetch_de_insn  = bypass ? icache_data : fq_insn[rd_ptr_q];
    assign fetch_de_error = !rst && (bypass ? icache_error : (!q_empty && fq_err[rd_ptr_q]));
`else
    assign fetch_de_valid = !rst && !q_empty;
    assign fetch_de_addr  = fq_addr[rd_ptr_q];
    assign fetch_de_insn  = fq_insn[rd_ptr_q];
    assign fetch_de_error = !rst && !q_empty && fq_err[rd_ptr_q];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_ADDR;
            resp_pc_q  <= RESET_ADDR;
            inflight_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (redirect_valid) begin
            state_q    <= RUN;
            pc_q       <= redirect_addr;
            resp_pc_q  <= redirect_addr;
            inflight_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (issue)
                pc_q <= pc_q + 30'd1;
            if (resp)
                resp_pc_q <= resp_pc_q + 30'd1;
            if (issue && !resp)
                inflight_q <= inflight_q + CNT_ONE;
            else if (!issue && resp)
                inflight_q <= inflight_q - CNT_ONE;
            if (enq)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (deq)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (enq && !deq)
                count_q <= count_q + CNT_ONE;
            else if (!enq && deq)
                count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fq_addr[wr_ptr_q] <= resp_pc_q;
            fq_insn[wr_ptr_q] <= icache_data;
            fq_err[wr_ptr_q]  <= icache_error;
        end
    end

endmodule

// File: tb/tb_fetch_ifu.sv
// tb_fetch_ifu: directed stimulus with an in-order scoreboard on the decode port of fetch_ifu.
module tb_fetch_ifu;
    localparam logic [29:0] RST_PC = 30'h2000_0000;
    localparam logic [29:0] NO_ERR = 30'h0BAD_0BAD;
`ifdef FETCH_BYPASS_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [29:0] redirect_addr = '0;
    logic        fetch_ic_req, fetch_ic_flush;
    logic [29:0] fetch_ic_addr;
    logic        icache_ready = 1'b1;
    logic        icache_valid, icache_error;
    logic [31:0] icache_data;
    logic        fetch_de_valid, fetch_de_error;
    logic [29:0] fetch_de_addr;
    logic [31:0] fetch_de_insn;
    logic        decode_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_ifu #(.RESET_ADDR(30'h2000_0000), .FQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .fetch_ic_req(fetch_ic_req), .fetch_ic_addr(fetch_ic_addr), .fetch_ic_flush(fetch_ic_flush),
        .icache_ready(icache_ready), .icache_valid(icache_valid), .icache_error(icache_error),
        .icache_data(icache_data),
        .fetch_de_valid(fetch_de_valid), .fetch_de_addr(fetch_de_addr),
        .fetch_de_insn(fetch_de_insn), .fetch_de_error(fetch_de_error),
        .decode_ready(decode_ready)
    );

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] insn;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned total = 0;
    int unsigned bad = 0;

    function automatic logic [31:0] insn_of(input logic [29:0] a);
        return ~{a, 2'b00};
    endfunction

    // Two-stage icache: response two cycles after acceptance, flush kills both stages.
    logic        s1v = 1'b0, s2v = 1'b0;
    logic [29:0] s1a = '0, s2a = '0;
    logic [29:0] err_addr = NO_ERR;
    int unsigned req_cnt = 0;
    logic [29:0] last_req = '0;

    always @(posedge clk) begin
        if (fetch_ic_flush) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
        end else begin
            s1v <= fetch_ic_req && icache_ready;
            s1a <= fetch_ic_addr;
            s2v <= s1v;
            s2a <= s1a;
        end
        if (fetch_ic_req && icache_ready) begin
            req_cnt  <= req_cnt + 1;
            last_req <= fetch_ic_addr;
        end
    end

    assign icache_valid = s2v;
    assign icache_data  = insn_of(s2a);
    assign icache_error = s2v && (s2a == err_addr);

    // Decode accepts only while it still has expected instructions outstanding.
    always @(posedge clk) begin
        #2;
        decode_ready = (exp_q.size() != 0);
    end

    always @(negedge clk) begin
        if (!rst && !redirect_valid && fetch_de_valid && decode_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL de_extra got addr=%h want none", fetch_de_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({fetch_de_addr, fetch_de_insn, fetch_de_error} !== mon_e) begin
                    bad++;
                    $display("FAIL de_out got addr=%h insn=%h err=%b want addr=%h insn=%h err=%b",
                             fetch_de_addr, fetch_de_insn, fetch_de_error,
                             mon_e.addr, mon_e.insn, mon_e.err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic push_exp(input logic [29:0] a, input logic e);
        exp_t x;
        x.addr = a;
        x.insn = insn_of(a);
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic wait_empty(input string name);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            next();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int unsigned nstream;
        int unsigned base;

        // Reset values
        next();
        next();
        mid();
        check("rst_req", 32'(fetch_ic_req), 32'd0);
        check("rst_flush", 32'(fetch_ic_flush), 32'd1);
        check("rst_de_valid", 32'(fetch_de_valid), 32'd0);
        check("rst_de_error", 32'(fetch_de_error), 32'd0);
        next();
        for (int i = 0; i < 12; i++) push_exp(RST_PC + 30'(i), 1'b0);
        rst = 1'b0;

        // Streaming from the reset address
        nstream = 0;
        for (int c = 0; c < int'(LAT) + 10; c++) begin
            mid();
            if (c == 0) begin
                check("first_req", 32'(fetch_ic_req), 32'd1);
                check("first_addr", {2'b00, fetch_ic_addr}, 32'h2000_0000);
            end
            if (c == int'(LAT) - 1)
                check("lat_before", 32'(fetch_de_valid), 32'd0);
            if (c == int'(LAT))
                check("lat_first_addr", {2'b00, fetch_de_addr}, 32'h2000_0000);
            if (c >= int'(LAT) && fetch_de_valid && decode_ready)
                nstream++;
            next();
        end
        check("stream_rate", nstream, 32'd10);
        wait_empty("stream_drain");

        // Decode backpressure: queue fills and issue stops on credit
        for (int i = 0; i < 10; i++) begin
            mid();
            if (i == 1)
                check("bp_head_early", {2'b00, fetch_de_addr}, 32'h2000_000C);
            next();
        end
        mid();
        check("bp_req_off", 32'(fetch_ic_req), 32'd0);
        check("bp_req_cnt", req_cnt, 32'd16);
        check("bp_last_req", {2'b00, last_req}, 32'h2000_000F);
        check("bp_head_valid", 32'(fetch_de_valid), 32'd1);
        check("bp_head_hold", {2'b00, fetch_de_addr}, 32'h2000_000C);
        next();
        for (int i = 12; i < 20; i++) push_exp(RST_PC + 30'(i), 1'b0);
        wait_empty("bp_drain");

        // Redirect with two requests in flight and a stale response in the flush cycle
        redirect_valid = 1'b1;
        redirect_addr  = 30'h0000_0080;
        mid();
        check("rd1_flush", 32'(fetch_ic_flush), 32'd1);
        next();
        redirect_valid = 1'b0;
        mid();
        check("rd1_req_addr", {2'b00, fetch_ic_addr}, 32'h0000_0080);
        next();
        mid();
        next();
        redirect_valid = 1'b1;
        redirect_addr  = 30'h0000_0100;
        mid();
        check("rd2_flush", 32'(fetch_ic_flush), 32'd1);
        check("rd2_no_req", 32'(fetch_ic_req), 32'd0);
        next();
        redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) push_exp(30'h0000_0100 + 30'(i), 1'b0);
        for (int c = 1; c <= int'(LAT) + 1; c++) begin
            mid();
            if (c == 1) begin
                check("rd2_req", 32'(fetch_ic_req), 32'd1);
                check("rd2_req_addr", {2'b00, fetch_ic_addr}, 32'h0000_0100);
                check("rd2_q_empty", 32'(fetch_de_valid), 32'd0);
            end
            if (c == int'(LAT))
                check("rd2_lat_before", 32'(fetch_de_valid), 32'd0);
            if (c == int'(LAT) + 1) begin
                check("rd2_lat_valid", 32'(fetch_de_valid), 32'd1);
                check("rd2_lat_addr", {2'b00, fetch_de_addr}, 32'h0000_0100);
            end
            next();
        end
        wait_empty("rd2_drain");

        // Access fault on 2000_0002: delivered with error, younger responses dropped, fetch halts
        redirect_valid = 1'b1;
        redirect_addr  = RST_PC;
        err_addr       = 30'h2000_0002;
        mid();
        base = req_cnt;
        next();
        redirect_valid = 1'b0;
        push_exp(30'h2000_0000, 1'b0);
        push_exp(30'h2000_0001, 1'b0);
        push_exp(30'h2000_0002, 1'b1);
        wait_empty("err_drain");
        repeat (8) begin
            mid();
            next();
        end
        mid();
        check("halt_req", 32'(fetch_ic_req), 32'd0);
        check("halt_de_valid", 32'(fetch_de_valid), 32'd0);
        check("halt_req_cnt", req_cnt - base, 32'd5);
        check("halt_last_req", {2'b00, last_req}, 32'h2000_0004);
        next();

        // Redirect out of halt across the PC wrap, then an icache stall
        redirect_valid = 1'b1;
        redirect_addr  = 30'h3FFF_FFFE;
        err_addr       = NO_ERR;
        mid();
        check("wr_flush", 32'(fetch_ic_flush), 32'd1);
        next();
        redirect_valid = 1'b0;
        push_exp(30'h3FFF_FFFE, 1'b0);
        push_exp(30'h3FFF_FFFF, 1'b0);
        push_exp(30'h0000_0000, 1'b0);
        push_exp(30'h0000_0001, 1'b0);
        mid();
        check("wr_addr0", {2'b00, fetch_ic_addr}, 32'h3FFF_FFFE);
        next();
        mid();
        check("wr_addr1", {2'b00, fetch_ic_addr}, 32'h3FFF_FFFF);
        next();
        mid();
        check("wr_req2", 32'(fetch_ic_req), 32'd1);
        check("wr_addr2", {2'b00, fetch_ic_addr}, 32'h0000_0000);
        next();
        icache_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("stall_req", 32'(fetch_ic_req), 32'd0);
            next();
        end
        icache_ready = 1'b1;
        mid();
        check("stall_resume_req", 32'(fetch_ic_req), 32'd1);
        check("stall_resume_addr", {2'b00, fetch_ic_addr}, 32'h0000_0001);
        next();
        wait_empty("wr_drain");

        // Reset with a full queue
        repeat (10) begin
            mid();
            next();
        end
        mid();
        check("full_valid", 32'(fetch_de_valid), 32'd1);
        check("full_head", {2'b00, fetch_de_addr}, 32'h0000_0002);
        next();
        rst = 1'b1;
        mid();
        check("mrst_flush", 32'(fetch_ic_flush), 32'd1);
        check("mrst_req", 32'(fetch_ic_req), 32'd0);
        check("mrst_de_valid", 32'(fetch_de_valid), 32'd0);
        check("mrst_de_error", 32'(fetch_de_error), 32'd0);
        next();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(RST_PC + 30'(i), 1'b0);
        mid();
        check("mrst_after_valid", 32'(fetch_de_valid), 32'd0);
        check("mrst_after_req", 32'(fetch_ic_req), 32'd1);
        check("mrst_after_addr", {2'b00, fetch_ic_addr}, 32'h2000_0000);
        next();
        wait_empty("mrst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
